shufflenet_mul_rr_arbiter: RTL and testbench

- Shares one pipelined 12x10 unsigned DSP48 multiplier among NUM_REQ requesters, e.g. conv channel lanes in the ShuffleNetV2 accelerator.
- Uses round-robin, burst-granular arbitration with valid/ready operand handshakes.
- Routes each product back to its issuing requester as a one-hot valid pulse on a shared result bus.
- Lets several low-duty kernels time-multiplex a single DSP slice instead of instantiating one multiplier each.

---
 rtl/shufflenet_mul_pkg.sv | 42 ++++
 rtl/shufflenet_mul_pipe.sv | 101 ++++++++++
 rtl/shufflenet_mul_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_shufflenet_mul_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shufflenet_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shufflenet_mul_pkg
//  Description : Shared types, default widths and round-robin pick helper
//                for the shared-multiplier arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package shufflenet_mul_pkg;

  localparam int A_W_DEF = 12;
  localparam int B_W_DEF = 10;
  localparam int P_W_DEF = 22;
  // Requester index / tag width, sized for the largest supported NUM_REQ (8)
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // First set bit of valid at or above ptr, wrapping at n. ptr must be < n.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [7:0]       valid,
                                               input logic [IDX_W-1:0] ptr,
                                               input logic [3:0]       n);
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [3:0]       idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) < n) && valid[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shufflenet_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shufflenet_mul_pipe
//  Description : MUL_LAT-stage unsigned multiplier with a parallel valid/tag
//                shift chain. Operand regs, product reg and a held output reg
//                map onto the DSP48 A/B, M and P registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module shufflenet_mul_pipe
  import shufflenet_mul_pkg::*;
#(
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = P_W_DEF,
  parameter int TAG_W   = IDX_W,
  parameter int MUL_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [P_W-1:0]   p_o,
  output logic             busy_o
);

  // Number of product-carrying registers, the last one being the held output
  localparam int P_ST = (MUL_LAT >= 2) ? MUL_LAT - 1 : 1;

  logic [MUL_LAT-1:0] valid_q;
  logic [MUL_LAT:0]   w_vchain;
  logic [TAG_W-1:0]   tag_q [MUL_LAT];
  logic [A_W-1:0]     w_a;
  logic [B_W-1:0]     w_b;
  logic [P_W-1:0]     w_prod;
  logic [P_W-1:0]     p_q;

  // w_vchain[k] is the valid of the beat entering stage k on the next edge
  assign w_vchain = {valid_q, valid_i};
  assign w_prod   = {{B_W{1'b0}}, w_a} * {{A_W{1'b0}}, w_b};

  // Valid and tag travel alongside the data; cleared on reset so nothing
  // in flight survives it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
    end else begin
      valid_q  <= w_vchain[MUL_LAT-1:0];
      tag_q[0] <= tag_i;
      for (int k = 1; k < MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  generate
    if (MUL_LAT >= 2) begin : g_inreg
      logic [A_W-1:0] a_q;
      logic [B_W-1:0] b_q;
      // Operand registers (DSP A/B regs)
      always_ff @(posedge clk_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      assign w_a = a_q;
      assign w_b = b_q;
    end else begin : g_noinreg
      assign w_a = a_i;
      assign w_b = b_i;
    end

    if (P_ST == 1) begin : g_pdirect
      // Output register loads only for a live beat so the bus holds otherwise
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 p_q <= '0;
        else if (w_vchain[MUL_LAT-1]) p_q <= w_prod;
      end
    end else begin : g_pchain
      logic [P_W-1:0] mid_q [P_ST-1];
      // Product and intermediate registers (DSP M reg and beyond)
      always_ff @(posedge clk_i) begin
        mid_q[0] <= w_prod;
        for (int k = 1; k < P_ST - 1; k++) mid_q[k] <= mid_q[k-1];
      end
      // Held output register (DSP P reg)
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 p_q <= '0;
        else if (w_vchain[MUL_LAT-1]) p_q <= mid_q[P_ST-2];
      end
    end
  endgenerate

  assign valid_o = valid_q[MUL_LAT-1];
  assign tag_o   = tag_q[MUL_LAT-1];
  assign p_o     = p_q;
  assign busy_o  = |valid_q;

endmodule
`default_nettype wire

// File: rtl/shufflenet_mul_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shufflenet_mul_rr_arbiter
//  Description : Round-robin, burst-granular arbiter sharing one pipelined
//                unsigned multiplier among NUM_REQ requesters; products are
//                returned as one-hot tagged pulses on a shared bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module shufflenet_mul_rr_arbiter
  import shufflenet_mul_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int A_W       = A_W_DEF,
  parameter int B_W       = B_W_DEF,
  parameter int P_W       = P_W_DEF,
  parameter int MUL_LAT   = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [P_W-1:0]         rsp_p,
  output logic                   busy
);

  localparam int BCNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [7:0]        w_valid8;
  logic [7:0]        w_last8;
  logic              w_issue;
  logic              w_release;
  logic [IDX_W-1:0]  w_owner_next;
  logic [A_W-1:0]    w_a;
  logic [B_W-1:0]    w_b;
  logic              w_pipe_valid;
  logic [IDX_W-1:0]  w_pipe_tag;
  logic              w_pipe_busy;

  assign w_valid8     = 8'(req_valid);
  assign w_last8      = 8'(req_last);
  assign w_issue      = (state_q == ST_BURST) && w_valid8[owner_q];
  assign w_release    = w_last8[owner_q] || (beat_cnt_q == BCNT_W'(MAX_BURST - 1));
  assign w_owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Arbitration state registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Grant selection in IDLE, beat counting and release in BURST
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          owner_d    = rr_pick(w_valid8, rr_ptr_q, 4'(NUM_REQ));
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_issue) begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (w_release) begin
            state_d  = ST_IDLE;
            rr_ptr_d = w_owner_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready goes only to the current owner, and only while the burst is open
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state_q == ST_BURST) && (owner_q == IDX_W'(i));
  end

  // Owner's operand slices feed the multiplier
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        w_a = req_a[i*A_W +: A_W];
        w_b = req_b[i*B_W +: B_W];
      end
    end
  end

  shufflenet_mul_pipe #(
    .A_W     (A_W),
    .B_W     (B_W),
    .P_W     (P_W),
    .TAG_W   (IDX_W),
    .MUL_LAT (MUL_LAT)
  ) u_pipe (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .valid_i (w_issue),
    .tag_i   (owner_q),
    .a_i     (w_a),
    .b_i     (w_b),
    .valid_o (w_pipe_valid),
    .tag_o   (w_pipe_tag),
    .p_o     (rsp_p),
    .busy_o  (w_pipe_busy)
  );

  // Decode the returning tag into the one-hot result strobe
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = w_pipe_valid && (w_pipe_tag == IDX_W'(i));
  end

  assign busy = (state_q == ST_BURST) || w_pipe_busy;

endmodule
`default_nettype wire

// File: tb/tb_shufflenet_mul_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shufflenet_mul_rr_arbiter
//  Description : Directed self-checking bench for the shared-multiplier
//                round-robin arbiter (NUM_REQ=4, MUL_LAT=3, MAX_BURST=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shufflenet_mul_rr_arbiter;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [47:0] req_a;
  logic [39:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [21:0] rsp_p;
  logic        busy;

  int n_cmp;
  int n_err;

  typedef struct {
    int         due;
    logic [3:0] oh;
    logic [21:0] p;
  } exp_t;
  exp_t q[$];

  shufflenet_mul_rr_arbiter #(
    .NUM_REQ   (4),
    .A_W       (12),
    .B_W       (10),
    .P_W       (22),
    .MUL_LAT   (3),
    .MAX_BURST (16)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [11:0] a, input logic [9:0] b);
    req_a[i*12 +: 12] = a;
    req_b[i*10 +: 10] = b;
  endtask

  initial begin
    int          seq [4];
    logic [21:0] prod [4];
    logic [3:0]  one;
    logic [3:0]  exp_oh;
    logic [3:0]  grant;
    logic [11:0] ta;
    logic [9:0]  tb;
    int          n1;

    n_cmp = 0;
    n_err = 0;
    one   = 4'b0001;
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_a     = '0;
    req_b     = '0;

    // ---------------- reset state ----------------
    tick(); tick(); tick();
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_p", rsp_p, 22'h0);
    chk("rst_busy", busy, 1'b0);
    ap_rst_n = 1'b1;

    // ---------------- single request from req 2 ----------------
    tick();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    set_op(2, 12'hFFF, 10'h3FF);
    #1;
    chk("single_idle_bubble", req_ready, 4'b0000);
    tick(); #1;
    chk("single_ready", req_ready, 4'b0100);
    chk("single_busy", busy, 1'b1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_released", req_ready, 4'b0000);
    chk("single_lat1", rsp_valid, 4'b0000);
    tick(); #1;
    chk("single_lat2", rsp_valid, 4'b0000);
    tick(); #1;
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_p", rsp_p, 22'h3FEC01);
    tick(); #1;
    chk("single_pulse_end", rsp_valid, 4'b0000);
    chk("single_p_hold", rsp_p, 22'h3FEC01);
    chk("single_idle_busy", busy, 1'b0);

    // ---------------- round robin, reqs 0/1/3, rr_ptr starts at 3 ----------------
    seq  = '{3, 0, 1, 3};
    prod = '{22'h004E6F, 22'h100000, 22'h000000, 22'h00006E};
    set_op(0, 12'h123, 10'h045);
    set_op(1, 12'h800, 10'h200);
    set_op(3, 12'h00A, 10'h00B);
    req_valid = 4'b1011;
    req_last  = 4'b1111;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      if (c == 8) req_valid = 4'b0000;
      #1;
      exp_oh = ((c % 2 == 1) && (c <= 7)) ? (one << seq[(c-1)/2]) : 4'b0000;
      chk("rr_ready", req_ready, exp_oh);
      exp_oh = ((c % 2 == 0) && (c >= 4)) ? (one << seq[(c-4)/2]) : 4'b0000;
      chk("rr_rsp_valid", rsp_valid, exp_oh);
      if (exp_oh != 4'b0000) chk("rr_rsp_p", rsp_p, prod[seq[(c-4)/2]]);
    end
    tick(); #1;
    chk("rr_drained_busy", busy, 1'b0);

    // ---------------- forced release after 16 beats ----------------
    n1 = 0;
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    set_op(3, 12'h001, 10'h001);
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      set_op(1, 12'(c), 10'h003);
      if (c == 2)  begin req_valid = 4'b1010; req_last = 4'b1000; end
      if (c == 19) req_valid = 4'b0010;
      if (c == 20) req_last  = 4'b0010;
      #1;
      if ((c <= 17) && req_ready[1] && req_valid[1]) n1++;
      if (c == 16) chk("burst_last_beat_ready", req_ready, 4'b0010);
      if (c == 17) chk("burst_forced_release", req_ready, 4'b0000);
      if (c == 18) chk("burst_other_served", req_ready, 4'b1000);
      if (c == 19) chk("burst_gap", req_ready, 4'b0000);
      if (c == 20) chk("burst_regrant", req_ready, 4'b0010);
    end
    chk("burst_beat_count", n1, 16);
    tick();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    tick(); tick(); tick(); tick();

    // ---------------- owner stall ----------------
    req_valid = 4'b0001;
    set_op(0, 12'h005, 10'h007);
    #1;
    chk("stall_idle", req_ready, 4'b0000);
    tick(); #1;
    chk("stall_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    set_op(2, 12'h002, 10'h002);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      #1;
      chk("stall_ready_held", req_ready, 4'b0001);
      chk("stall_rsp_valid", rsp_valid, (j == 2) ? 4'b0001 : 4'b0000);
      if (j == 2) chk("stall_rsp_p", rsp_p, 22'h000023);
    end
    tick();
    req_valid = 4'b0101;
    req_last  = 4'b0101;
    set_op(0, 12'h006, 10'h009);
    #1;
    chk("stall_resume", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("stall_release", req_ready, 4'b0000);
    tick(); #1;
    chk("stall_next_owner", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    chk("stall_resume_rsp", rsp_valid, 4'b0001);
    chk("stall_resume_p", rsp_p, 22'h000036);
    tick(); tick(); tick(); tick();

    // ---------------- reset with products in flight ----------------
    req_valid = 4'b0010;
    set_op(1, 12'h010, 10'h010);
    tick(); tick(); tick(); tick();
    #1;
    chk("mid_pre_rsp", rsp_valid, 4'b0010);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 4'b0000);
    chk("mid_rst_rsp_valid", rsp_valid, 4'b0000);
    chk("mid_rst_rsp_p", rsp_p, 22'h0);
    chk("mid_rst_busy", busy, 1'b0);
    req_valid = 4'b0000;
    tick(); tick();
    ap_rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick(); #1;
      chk("post_rst_no_rsp", rsp_valid, 4'b0000);
      chk("post_rst_busy", busy, 1'b0);
    end
    req_valid = 4'b1100;
    req_last  = 4'b1100;
    set_op(2, 12'h0FF, 10'h101);
    #1;
    chk("post_rst_idle", req_ready, 4'b0000);
    tick(); #1;
    chk("post_rst_lowest", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    tick(); tick(); #1;
    chk("post_rst_rsp_valid", rsp_valid, 4'b0100);
    chk("post_rst_rsp_p", rsp_p, 22'h00FFFF);

    // ---------------- random traffic against a scoreboard ----------------
    for (int k = 0; k < 2006; k++) begin
      tick();
      if (k < 2000) begin
        req_valid = 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) begin
          req_last[i] = ($urandom_range(0, 3) == 0);
          set_op(i, 12'($urandom()), 10'($urandom()));
        end
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if ((q.size() > 0) && (q[0].due == k)) begin
        chk("rnd_rsp_valid", rsp_valid, q[0].oh);
        chk("rnd_rsp_p", rsp_p, q[0].p);
        void'(q.pop_front());
      end else begin
        chk("rnd_no_rsp", rsp_valid, 4'b0000);
      end
      chk("rnd_ready_onehot", ($countones(req_ready) <= 1), 1'b1);
      grant = req_valid & req_ready;
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) begin
          ta = req_a[i*12 +: 12];
          tb = req_b[i*10 +: 10];
          q.push_back('{k + 3, grant, 22'(ta) * 22'(tb)});
        end
      end
    end
    chk("rnd_all_returned", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
